// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage: the fetch FSM state
// encoding, the default reset PC, the default halt opcode and the word that
// fills bubble / flushed IF/ID entries.
// ---------------------------------------------------------------------------
package if_pkg;

  // Fetch FSM states.
  //   RUN       : normal fetch, imem_addr = pc
  //   MISS      : waiting on the cache for the word at pc
  //   MISS_DROP : waiting on a fill that was made wrong-path by a redirect
  //   HALT      : HLT latched, fetch frozen until reset
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS      = 2'd1,
    MISS_DROP = 2'd2,
    HALT      = 2'd3
  } if_state_e;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] NOP_WORD   = 16'h0000;

endpackage : if_pkg

// File: rtl/CLA_16bit.sv
// ---------------------------------------------------------------------------
// CLA_16bit
// 16-bit carry-lookahead adder/subtractor built from four 4-bit lookahead
// groups with a second lookahead level across the groups.
// Ports:
//   a, b  : operands
//   sub   : 0 = a + b, 1 = a - b (two's complement, b inverted, carry-in 1)
//   sum   : result, modulo 2^16
// ---------------------------------------------------------------------------
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);

  logic [15:0] b_eff;
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [15:0] c;

  // Bit-level generate / propagate; subtraction inverts b.
  assign b_eff = b ^ {16{sub}};
  assign g     = a & b_eff;
  assign p     = a ^ b_eff;

  // Group generate / propagate for each nibble.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Carries: group carry-ins come from the second lookahead level, carries
  // inside a nibble are expanded from that nibble's carry-in.
  always_comb begin
    c     = '0;
    c[0]  = sub;
    c[4]  = grp_g[0] | (grp_p[0] & sub);
    c[8]  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & sub);
    c[12] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & sub);
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum = p ^ c;

endmodule : CLA_16bit

// File: rtl/if_fetch_pc.sv
// ---------------------------------------------------------------------------
// if_fetch_pc
// Instruction-fetch stage: owns the PC, drives the instruction-cache address,
// waits out cache misses, loads the IF/ID register and freezes on HLT.
//
// Optional feature macro: IF_PERF_CNT_EN
//   defined   -> perf_fetches / perf_miss_cycles are saturating counters
//   undefined -> both ports read 16'h0000 and no counter flops exist
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   next_pc           next fetch address chosen by next-address logic
//   redirect          taken branch from ID; current IF word is wrong-path
//   stall             hazard stall from ID; hold PC, IF/ID and state
//   imem_addr         instruction-cache address
//   imem_data         instruction word, valid when imem_valid=1
//   imem_valid        cache has the word for imem_addr this cycle
//   pc_plus2          pc + 2 (combinational) for next-address logic
//   if_id_instr       IF/ID instruction (NOP_WORD when not valid)
//   if_id_pc_plus2    IF/ID PC+2
//   if_id_valid       IF/ID holds a real instruction
//   halted            fetch frozen on HLT
//   perf_fetches      instructions latched valid
//   perf_miss_cycles  cycles spent waiting on the cache
// ---------------------------------------------------------------------------
module if_fetch_pc
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = if_pkg::RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = if_pkg::HLT_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] pc_plus2,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] perf_fetches,
  output logic [15:0] perf_miss_cycles
);

  if_state_e   state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] miss_addr_q, miss_addr_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc2_q, if_pc2_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;

  CLA_16bit u_pc_adder (
    .a   (pc_q),
    .b   (16'h0002),
    .sub (1'b0),
    .sum (pc_plus2)
  );

  // While a wrong-path fill is outstanding the cache keeps seeing the old
  // address, so the fill completes and can be thrown away cleanly.
  assign imem_addr = (state_q == MISS_DROP) ? miss_addr_q : pc_q;

  // Next-state logic for PC, FSM and IF/ID.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    if_instr_d  = if_instr_q;
    if_pc2_d    = if_pc2_q;
    if_valid_d  = if_valid_q;
    halted_d    = halted_q;

    if (stall) begin
      // Everything architectural holds, but the cache wait keeps going: once
      // the word arrives the FSM returns to RUN and relatches it after the
      // stall (the cache holds imem_valid high meanwhile).
      if ((state_q == MISS || state_q == MISS_DROP) && imem_valid) begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN, MISS: begin
          if (imem_valid) begin
            if (redirect) begin
              pc_d       = next_pc;
              if_instr_d = NOP_WORD;
              if_valid_d = 1'b0;
              state_d    = RUN;
            end else begin
              if_instr_d = imem_data;
              if_pc2_d   = pc_plus2;
              if_valid_d = 1'b1;
              if (imem_data[15:12] == HLT_OPCODE) begin
                state_d  = HALT;
                halted_d = 1'b1;
              end else begin
                pc_d    = next_pc;
                state_d = RUN;
              end
            end
          end else begin
            miss_addr_d = pc_q;
            if_instr_d  = NOP_WORD;
            if_valid_d  = 1'b0;
            if (redirect) begin
              pc_d    = next_pc;
              state_d = MISS_DROP;
            end else begin
              state_d = MISS;
            end
          end
        end
        MISS_DROP: begin
          if_instr_d = NOP_WORD;
          if_valid_d = 1'b0;
          if (redirect) begin
            pc_d = next_pc;
          end
          if (imem_valid) begin
            state_d = RUN;
          end
        end
        HALT: begin
          if_instr_d = NOP_WORD;
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= 16'h0000;
      if_instr_q  <= NOP_WORD;
      if_pc2_q    <= 16'h0000;
      if_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      if_instr_q  <= if_instr_d;
      if_pc2_q    <= if_pc2_d;
      if_valid_q  <= if_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign if_id_instr    = if_instr_q;
  assign if_id_pc_plus2 = if_pc2_q;
  assign if_id_valid    = if_valid_q;
  assign halted         = halted_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetches_q, perf_fetches_d;
  logic [15:0] perf_miss_q, perf_miss_d;
  logic        latch_valid;
  logic        wait_cycle;

  // A valid latch is a non-stalled, non-redirected word arriving in RUN or
  // MISS. A wait cycle is any non-HALT cycle where the cache has not
  // delivered yet; the cycle on which the fill arrives is not counted.
  always_comb begin
    latch_valid = !stall && !redirect && imem_valid
                  && (state_q == RUN || state_q == MISS);
    wait_cycle  = !imem_valid && (state_q != HALT);
    perf_fetches_d = perf_fetches_q;
    perf_miss_d    = perf_miss_q;
    if (latch_valid && perf_fetches_q != 16'hFFFF) begin
      perf_fetches_d = perf_fetches_q + 16'd1;
    end
    if (wait_cycle && perf_miss_q != 16'hFFFF) begin
      perf_miss_d = perf_miss_q + 16'd1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetches_q <= 16'h0000;
      perf_miss_q    <= 16'h0000;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_miss_q    <= perf_miss_d;
    end
  end

  assign perf_fetches     = perf_fetches_q;
  assign perf_miss_cycles = perf_miss_q;
`else
  assign perf_fetches     = 16'h0000;
  assign perf_miss_cycles = 16'h0000;
`endif

endmodule : if_fetch_pc
